// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_package
// Description : Definitions shared by the UART receive engine and the RX FIFO:
//               receive state encoding, error-flag field positions within a
//               FIFO word, and the expected-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_package;

    // Width of one RX FIFO entry: {break, framing_err, parity_err, data[7:0]}
    localparam int UART_WORD_W = 11;
    localparam int ERR_PE      = 8;
    localparam int ERR_FE      = 9;
    localparam int ERR_BI      = 10;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Parity bit the transmitter should have sent. Unreceived data bits are
    // held at zero, so reducing over all eight bits covers received bits only.
    function automatic logic parity_expected(input logic [7:0] data,
                                             input logic       eps,
                                             input logic       sp);
        if (sp) begin
            return ~eps;
        end
        return eps ? ^data : ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous serial input.
//               Both flops reset to 1 so the line reads idle out of reset.
// Ports       : clk_i  - system clock
//               nrst_i - asynchronous active-low reset
//               d_i    - asynchronous input
//               q_o    - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16550-style serial receive engine. Oversamples the line at
//               16x baud, deframes 5-8 data bits with optional parity, checks
//               the first stop bit and writes {bi, fe, pe, data} to the RX
//               FIFO push port once per character.
// Ports       : clk_i, nrst_i     - clock, async active-low reset
//               baud_tick_i       - 16x baud enable
//               rxd_i             - serial line (async, idle high)
//               lcr_wls/pen/eps/sp- line control fields
//               fifo_full_i       - RX FIFO full
//               clear_i           - RX FIFO clear (discards completing char)
//               push_o/push_dat_o - FIFO write strobe and word
//               overrun_o         - pulse: character lost on full FIFO
//               rx_busy_o         - receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_package::*;
#(
    parameter int DATA_WIDTH = UART_WORD_W
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic                  baud_tick_i,
    input  logic                  rxd_i,
    input  logic [1:0]            lcr_wls,
    input  logic                  lcr_pen,
    input  logic                  lcr_eps,
    input  logic                  lcr_sp,
    input  logic                  fifo_full_i,
    input  logic                  clear_i,
    output logic                  push_o,
    output logic [DATA_WIDTH-1:0] push_dat_o,
    output logic                  overrun_o,
    output logic                  rx_busy_o
);

    logic                   w_rxd_s;
    rx_state_t              r_state;
    logic [3:0]             r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_data;
    logic                   r_par;
    logic                   r_pe;
    logic                   w_last_bit;
    logic [UART_WORD_W-1:0] w_word;

    uart_rx_sync u_sync (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .d_i    (rxd_i),
        .q_o    (w_rxd_s)
    );

    // Word length is 5 + wls bits, so the final index is 4 + wls.
    assign w_last_bit = (r_idx == (3'd4 + {1'b0, lcr_wls}));

    // Completed word; fe/bi come from the stop-bit sample taken this tick.
    // r_par is cleared at frame start, so it reads 0 when parity is off.
    always_comb begin
        w_word         = '0;
        w_word[7:0]    = r_data;
        w_word[ERR_PE] = r_pe;
        w_word[ERR_FE] = ~w_rxd_s;
        w_word[ERR_BI] = (r_data == 8'h00) & (~lcr_pen | ~r_par) & ~w_rxd_s;
    end

    assign rx_busy_o = (r_state != RX_IDLE);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state    <= RX_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= 3'd0;
            r_data     <= 8'h00;
            r_par      <= 1'b0;
            r_pe       <= 1'b0;
            push_o     <= 1'b0;
            overrun_o  <= 1'b0;
            push_dat_o <= '0;
        end else begin
            push_o    <= 1'b0;
            overrun_o <= 1'b0;
            if (baud_tick_i) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rxd_s) begin
                            r_state <= RX_START;
                            r_cnt   <= 4'd0;
                        end
                    end
                    RX_START: begin
                        if (r_cnt == 4'd7) begin
                            // Line back high at mid start bit: a glitch.
                            if (w_rxd_s) begin
                                r_state <= RX_IDLE;
                            end else begin
                                r_state <= RX_DATA;
                                r_cnt   <= 4'd0;
                                r_idx   <= 3'd0;
                                r_data  <= 8'h00;
                                r_par   <= 1'b0;
                                r_pe    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_data[r_idx] <= w_rxd_s;
                            if (w_last_bit) begin
                                r_state <= lcr_pen ? RX_PARITY : RX_STOP;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_par   <= w_rxd_s;
                            r_pe    <= (w_rxd_s != parity_expected(r_data, lcr_eps, lcr_sp));
                            r_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            push_dat_o <= w_word;
                            // A FIFO clear in this cycle discards the character
                            // outright; it is not an overrun.
                            if (!clear_i) begin
                                if (fifo_full_i) begin
                                    overrun_o <= 1'b1;
                                end else begin
                                    push_o <= 1'b1;
                                end
                            end
                            r_state <= w_rxd_s ? RX_IDLE : RX_WAIT_HIGH;
                        end
                    end
                    RX_WAIT_HIGH: begin
                        // Line held low (break): no new start until it idles.
                        r_cnt <= r_cnt + 4'd1;
                        if (w_rxd_s) begin
                            r_state <= RX_IDLE;
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Directed frames from the
//               block's test plan plus randomised frames checked against a
//               word-level reference model of the framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic        clk_i       = 1'b0;
    logic        nrst_i      = 1'b0;
    logic        baud_tick_i = 1'b0;
    logic        rxd_i       = 1'b1;
    logic [1:0]  lcr_wls     = 2'b11;
    logic        lcr_pen     = 1'b0;
    logic        lcr_eps     = 1'b0;
    logic        lcr_sp      = 1'b0;
    logic        fifo_full_i = 1'b0;
    logic        clear_i     = 1'b0;
    logic        push_o;
    logic [10:0] push_dat_o;
    logic        overrun_o;
    logic        rx_busy_o;

    int n_pass   = 0;
    int n_total  = 0;
    int tick_cnt = 0;
    int push_cnt = 0;
    int ovr_cnt  = 0;
    logic [1:0] r_div = 2'd0;

    uart_rx dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .baud_tick_i (baud_tick_i),
        .rxd_i       (rxd_i),
        .lcr_wls     (lcr_wls),
        .lcr_pen     (lcr_pen),
        .lcr_eps     (lcr_eps),
        .lcr_sp      (lcr_sp),
        .fifo_full_i (fifo_full_i),
        .clear_i     (clear_i),
        .push_o      (push_o),
        .push_dat_o  (push_dat_o),
        .overrun_o   (overrun_o),
        .rx_busy_o   (rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // 16x baud enable: one clock in four, changed on the falling edge.
    always @(negedge clk_i) begin
        r_div       = r_div + 2'd1;
        baud_tick_i = (r_div == 2'd0);
    end

    always @(posedge clk_i) begin
        if (baud_tick_i) tick_cnt <= tick_cnt + 1;
    end

    // Strobe monitor: counts clock cycles each strobe is high.
    always @(negedge clk_i) begin
        if (push_o)    push_cnt = push_cnt + 1;
        if (overrun_o) ovr_cnt  = ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        int tgt;
        tgt = tick_cnt + n;
        while (tick_cnt < tgt) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        rxd_i = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pb, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pb);
        send_bit(stopb);
        rxd_i = 1'b1;
        wait_ticks(24);
    endtask

    // Reference: word the receiver should produce for a frame described at
    // the character level.
    function automatic logic [10:0] exp_word(input logic [7:0] d, input int wls,
                                             input logic pen, input logic eps,
                                             input logic sp, input logic pb,
                                             input logic stopb);
        int   nb;
        int   ones;
        int   dm;
        logic expp;
        logic pe;
        logic fe;
        logic bi;
        nb   = 5 + wls;
        dm   = int'(d) % (1 << nb);
        ones = 0;
        for (int i = 0; i < nb; i++) ones += (dm >> i) & 1;
        if (sp)       expp = !eps;
        else if (eps) expp = (ones % 2 == 1);
        else          expp = (ones % 2 == 0);
        pe = pen && (pb != expp);
        fe = !stopb;
        bi = (dm == 0) && (!pen || !pb) && !stopb;
        return {bi, fe, pe, dm[7:0]};
    endfunction

    initial begin
        int p0;
        int o0;
        logic [7:0] d;
        int   wls;
        logic pen;
        logic eps;
        logic sp;
        logic pb;
        logic stopb;

        // Reset state
        repeat (4) @(negedge clk_i);
        chk("rst_push",    32'(push_o),     32'd0);
        chk("rst_dat",     32'(push_dat_o), 32'h000);
        chk("rst_overrun", 32'(overrun_o),  32'd0);
        chk("rst_busy",    32'(rx_busy_o),  32'd0);
        nrst_i = 1'b1;
        wait_ticks(4);

        // 8N1 0xA5
        p0 = push_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        chk("8n1_push_cycles", 32'(push_cnt - p0), 32'd1);
        chk("8n1_dat",         32'(push_dat_o),    32'h0A5);
        chk("8n1_overrun",     32'(ovr_cnt - o0),  32'd0);

        // 7E1 0x41 with wrong parity bit
        lcr_wls = 2'b10; lcr_pen = 1'b1; lcr_eps = 1'b1;
        p0 = push_cnt;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        chk("7e1_push_cycles", 32'(push_cnt - p0), 32'd1);
        chk("7e1_dat",         32'(push_dat_o),    32'h141);
        lcr_wls = 2'b11; lcr_pen = 1'b0; lcr_eps = 1'b0;

        // Glitch on the start bit
        p0 = push_cnt;
        rxd_i = 1'b0;
        wait_ticks(4);
        chk("glitch_busy_mid", 32'(rx_busy_o), 32'd1);
        rxd_i = 1'b1;
        wait_ticks(20);
        chk("glitch_push",     32'(push_cnt - p0), 32'd0);
        chk("glitch_busy_end", 32'(rx_busy_o),     32'd0);

        // Break: 20 bit times low
        p0 = push_cnt;
        rxd_i = 1'b0;
        wait_ticks(320);
        chk("brk_push_cycles", 32'(push_cnt - p0), 32'd1);
        chk("brk_dat",         32'(push_dat_o),    32'h600);
        chk("brk_busy_held",   32'(rx_busy_o),     32'd1);
        rxd_i = 1'b1;
        wait_ticks(4);
        chk("brk_busy_release", 32'(rx_busy_o),     32'd0);
        chk("brk_no_extra",     32'(push_cnt - p0), 32'd1);
        p0 = push_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        chk("post_brk_push", 32'(push_cnt - p0), 32'd1);
        chk("post_brk_dat",  32'(push_dat_o),    32'h055);

        // FIFO full at completion
        fifo_full_i = 1'b1;
        p0 = push_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        fifo_full_i = 1'b0;
        chk("full_push",           32'(push_cnt - p0), 32'd0);
        chk("full_overrun_cycles", 32'(ovr_cnt - o0),  32'd1);
        chk("full_dat",            32'(push_dat_o),    32'h03C);

        // FIFO clear at completion
        clear_i = 1'b1;
        p0 = push_cnt; o0 = ovr_cnt;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        clear_i = 1'b0;
        chk("clear_push",    32'(push_cnt - p0), 32'd0);
        chk("clear_overrun", 32'(ovr_cnt - o0),  32'd0);

        // Reset mid-DATA
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        nrst_i = 1'b0;
        rxd_i  = 1'b1;
        #1;
        chk("midrst_dat",  32'(push_dat_o), 32'h000);
        chk("midrst_busy", 32'(rx_busy_o),  32'd0);
        chk("midrst_push", 32'(push_o),     32'd0);
        @(negedge clk_i);
        nrst_i = 1'b1;
        wait_ticks(8);
        p0 = push_cnt;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        chk("post_rst_push", 32'(push_cnt - p0), 32'd1);
        chk("post_rst_dat",  32'(push_dat_o),    32'h081);

        // Randomised frames against the reference model
        for (int k = 0; k < 10; k++) begin
            d     = 8'($urandom);
            wls   = int'($urandom_range(0, 3));
            pen   = 1'($urandom_range(0, 1));
            eps   = 1'($urandom_range(0, 1));
            sp    = 1'($urandom_range(0, 1));
            pb    = 1'($urandom_range(0, 1));
            stopb = ($urandom_range(0, 3) != 0);
            if (k == 0) d = 8'h00;
            lcr_wls = 2'(wls); lcr_pen = pen; lcr_eps = eps; lcr_sp = sp;
            p0 = push_cnt;
            send_frame(d, 5 + wls, pen, pb, stopb);
            chk($sformatf("rand%0d_push", k), 32'(push_cnt - p0), 32'd1);
            chk($sformatf("rand%0d_dat", k), 32'(push_dat_o),
                32'(exp_word(d, wls, pen, eps, sp, pb, stopb)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
